uart_block_sched: RTL and testbench

UART_BLOCK_SCHED -- requirements
Module: uart_block_sched

---
 rtl/uart_block_sched_if.sv | 31 +++
 rtl/uart_block_sched.sv | 133 +++++++++++++
 tb/tb_uart_block_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_block_sched_if.sv
// Bundle of requester, UART and status signals for uart_block_sched.
// The slave modport is the scheduler; the master modport is whoever drives
// the requests and models the UART transmitter.
interface uart_block_sched_if;
    logic         req0_valid_i;
    logic         req1_valid_i;
    logic [127:0] req0_data_i;
    logic [127:0] req1_data_i;
    logic         req0_ack_o;
    logic         req1_ack_o;
    logic         uart_wr_o;
    logic [7:0]   uart_dat_o;
    logic         uart_busy_i;
    logic         done_o;
    logic         active_o;
    logic         cur_id_o;
    logic         err_o;
    logic [2:0]   state_dbg;

    modport master (
        output req0_valid_i, req1_valid_i, req0_data_i, req1_data_i, uart_busy_i,
        input  req0_ack_o, req1_ack_o, uart_wr_o, uart_dat_o, done_o,
        input  active_o, cur_id_o, err_o, state_dbg
    );

    modport slave (
        input  req0_valid_i, req1_valid_i, req0_data_i, req1_data_i, uart_busy_i,
        output req0_ack_o, req1_ack_o, uart_wr_o, uart_dat_o, done_o,
        output active_o, cur_id_o, err_o, state_dbg
    );
endinterface

// File: rtl/uart_block_sched.sv
// Two-requester block scheduler feeding a byte-wide UART transmitter.
// A granted 128-bit block is sent MSB byte first, optionally preceded by a
// header byte 8'hA0 | requester id.
//
// Handshakes: a requester holds valid high until it sees its one-cycle ack;
// data is captured only on the grant edge. Each UART byte is offered with a
// one-cycle write strobe while the transmitter is idle; the transmitter must
// then raise busy within BUSY_TMO cycles and drop it when the byte is gone.
module uart_block_sched #(
    parameter int HDR_EN   = 1,
    parameter int BUSY_TMO = 15
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    uart_block_sched_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_IDLE = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX = (HDR_EN != 0) ? 5'd16 : 5'd15;
    localparam logic [3:0] TMO_LAST = 4'(BUSY_TMO - 1);

    state_t       state;
    logic [127:0] shreg;
    logic [4:0]   byte_idx;
    logic [3:0]   tmo_cnt;
    logic         cur_id;
    logic         last_grant;
    logic         ack0;
    logic         ack1;
    logic [7:0]   dat;
    logic         done;
    logic         err;

    logic         grant_id;
    logic [127:0] grant_data;

    // Round-robin pick: on a tie the requester not served last wins.
    assign grant_id   = (bus.req0_valid_i && bus.req1_valid_i) ? ~last_grant : bus.req1_valid_i;
    assign grant_data = grant_id ? bus.req1_data_i : bus.req0_data_i;

    // Main scheduler FSM; all outputs except the write strobe are registered.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state      <= IDLE;
            shreg      <= '0;
            byte_idx   <= '0;
            tmo_cnt    <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            dat        <= 8'h00;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0_valid_i || bus.req1_valid_i) begin
                        cur_id   <= grant_id;
                        byte_idx <= '0;
                        ack0     <= ~grant_id;
                        ack1     <= grant_id;
                        if (HDR_EN != 0) begin
                            shreg <= grant_data;
                            dat   <= {7'b1010000, grant_id};
                        end else begin
                            shreg <= {grant_data[119:0], 8'h00};
                            dat   <= grant_data[127:120];
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.uart_busy_i) begin
                        tmo_cnt <= '0;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.uart_busy_i) begin
                        state <= WAIT_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (!bus.uart_busy_i) begin
                        if (byte_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                            dat      <= shreg[127:120];
                            shreg    <= {shreg[119:0], 8'h00};
                            state    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    last_grant <= cur_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The strobe must land in the very ISSUE cycle that sees busy low, so it
    // is decoded from the state register and the live busy flag.
    assign bus.uart_wr_o  = (state == ISSUE) && !bus.uart_busy_i;
    assign bus.uart_dat_o = dat;
    assign bus.req0_ack_o = ack0;
    assign bus.req1_ack_o = ack1;
    assign bus.done_o     = done;
    assign bus.active_o   = (state != IDLE);
    assign bus.cur_id_o   = cur_id;
    assign bus.err_o      = err;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_uart_block_sched.sv
// Randomized scoreboard bench for uart_block_sched.
// Instance 0: header enabled, BUSY_TMO 15. Instance 1: no header, BUSY_TMO 5.
module tb_uart_block_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_block_sched_if a_if ();
  uart_block_sched_if b_if ();

  uart_block_sched #(.HDR_EN(1), .BUSY_TMO(15)) dut_a (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (a_if)
  );

  uart_block_sched #(.HDR_EN(0), .BUSY_TMO(5)) dut_b (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (b_if)
  );

  // stimulus-side state, indexed [instance][requester]
  logic         rv    [2][2];
  logic [127:0] rd    [2][2];
  logic         mbusy [2];
  logic         fbusy [2];
  logic         stuck [2];

  assign a_if.req0_valid_i = rv[0][0];
  assign a_if.req1_valid_i = rv[0][1];
  assign a_if.req0_data_i  = rd[0][0];
  assign a_if.req1_data_i  = rd[0][1];
  assign a_if.uart_busy_i  = mbusy[0] | fbusy[0];
  assign b_if.req0_valid_i = rv[1][0];
  assign b_if.req1_valid_i = rv[1][1];
  assign b_if.req0_data_i  = rd[1][0];
  assign b_if.req1_data_i  = rd[1][1];
  assign b_if.uart_busy_i  = mbusy[1] | fbusy[1];

  // uniform views of the DUT outputs
  logic       wr_w   [2];
  logic [7:0] dat_w  [2];
  logic [1:0] ack_w  [2];
  logic       done_w [2];
  logic       act_w  [2];
  logic       id_w   [2];
  logic       err_w  [2];
  assign wr_w[0]   = a_if.uart_wr_o;
  assign wr_w[1]   = b_if.uart_wr_o;
  assign dat_w[0]  = a_if.uart_dat_o;
  assign dat_w[1]  = b_if.uart_dat_o;
  assign ack_w[0]  = {a_if.req1_ack_o, a_if.req0_ack_o};
  assign ack_w[1]  = {b_if.req1_ack_o, b_if.req0_ack_o};
  assign done_w[0] = a_if.done_o;
  assign done_w[1] = b_if.done_o;
  assign act_w[0]  = a_if.active_o;
  assign act_w[1]  = b_if.active_o;
  assign id_w[0]   = a_if.cur_id_o;
  assign id_w[1]   = b_if.cur_id_o;
  assign err_w[0]  = a_if.err_o;
  assign err_w[1]  = b_if.err_o;

  // scoreboard: {cur_id, byte} per expected write, expected ack ids
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic [0:0] ack_q0 [$];
  logic [0:0] ack_q1 [$];
  int         grant_log0 [$];

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt   [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  int rr_last  [2] = '{1, 1};

  logic [127:0] blk [2][3];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  function automatic int exp_len(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // reference model: the byte stream of one block
  function automatic void push_block(input int inst, input int id, input logic [127:0] data);
    logic [8:0] e;
    if (inst == 0) begin
      e = {id[0], 8'hA0 | 8'(id)};
      exp_q0.push_back(e);
    end
    for (int b = 15; b >= 0; b--) begin
      e = {id[0], data[8*b +: 8]};
      if (inst == 0) exp_q0.push_back(e);
      else           exp_q1.push_back(e);
    end
  endfunction

  // reference model: which requester is served in what order
  function automatic void model_blocks(input int inst, input int n0, input int n1);
    int rem [2];
    int k   [2];
    int w;
    rem[0] = n0; rem[1] = n1; k[0] = 0; k[1] = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) w = 1 - rr_last[inst];
      else                          w = (rem[0] > 0) ? 0 : 1;
      push_block(inst, w, blk[w][k[w]]);
      if (inst == 0) ack_q0.push_back(w[0]);
      else           ack_q1.push_back(w[0]);
      exp_done[inst]++;
      rr_last[inst] = w;
      rem[w]--;
      k[w]++;
    end
  endfunction

  // monitor: pops and compares whenever the DUT presents an output
  always @(negedge clk) begin
    logic [8:0] e;
    logic [0:0] ea;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_w[i]) begin
          wr_cnt[i]++;
          if (exp_len(i) == 0) begin
            fail_now($sformatf("unexpected_wr%0d byte 0x%0h", i, dat_w[i]));
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("wr_byte%0d", i), {23'd0, id_w[i], dat_w[i]}, {23'd0, e});
          end
        end
        if (ack_w[i] != 2'b00) begin
          if (ack_w[i] == 2'b11) begin
            fail_now($sformatf("double_ack%0d", i));
          end else if (((i == 0) ? ack_q0.size() : ack_q1.size()) == 0) begin
            fail_now($sformatf("unexpected_ack%0d", i));
          end else begin
            ea = (i == 0) ? ack_q0.pop_front() : ack_q1.pop_front();
            check($sformatf("ack_id%0d", i), {31'd0, ack_w[i][1]}, {31'd0, ea});
            if (i == 0) grant_log0.push_back(int'(ack_w[i][1]));
          end
        end
        if (done_w[i]) done_cnt[i]++;
      end
    end
  end

  // UART transmitter model: busy rises 1..3 cycles after a write, lasts 1..4
  task automatic uart_model(input int inst);
    int d;
    int h;
    mbusy[inst] = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_w[inst] && !stuck[inst]) begin
        d = $urandom_range(0, 2);
        h = $urandom_range(1, 4);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1 mbusy[inst] = 1'b1;
        repeat (h) @(posedge clk);
        #1 mbusy[inst] = 1'b0;
      end
    end
  endtask

  initial uart_model(0);
  initial uart_model(1);

  // requester driver: n blocks back to back, valid held until each ack
  task automatic requester(input int inst, input int id, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      rd[inst][id] = blk[id][k];
      rv[inst][id] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ack_w[inst][id] && t < 4000);
      if (t >= 4000) fail_now($sformatf("ack_timeout%0d_%0d", inst, id));
    end
    rv[inst][id] = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((act_w[inst] || exp_len(inst) != 0) && t < 6000);
    if (t >= 6000) fail_now($sformatf("idle_timeout%0d", inst));
  endtask

  task automatic run_pair(input int inst, input int n0, input int n1);
    model_blocks(inst, n0, n1);
    @(posedge clk);
    #1;
    fork
      if (n0 > 0) requester(inst, 0, n0);
      if (n1 > 0) requester(inst, 1, n1);
    join
    wait_idle(inst);
    check($sformatf("done_cnt%0d", inst), done_cnt[inst], exp_done[inst]);
  endtask

  function automatic void check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_active%0d", tag, i), {31'd0, act_w[i]}, 32'd0);
      check($sformatf("%s_wr%0d", tag, i),     {31'd0, wr_w[i]}, 32'd0);
      check($sformatf("%s_dat%0d", tag, i),    {24'd0, dat_w[i]}, 32'd0);
      check($sformatf("%s_ack%0d", tag, i),    {30'd0, ack_w[i]}, 32'd0);
      check($sformatf("%s_done%0d", tag, i),   {31'd0, done_w[i]}, 32'd0);
      check($sformatf("%s_id%0d", tag, i),     {31'd0, id_w[i]}, 32'd0);
      check($sformatf("%s_err%0d", tag, i),    {31'd0, err_w[i]}, 32'd0);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int cnt;
    int rr_exp [3];
    for (int i = 0; i < 2; i++) begin
      fbusy[i] = 1'b0;
      stuck[i] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        rv[i][j] = 1'b0;
        rd[i][j] = '0;
      end
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // both requesters held: req0 wants two blocks, req1 one -> 0,1,0
    for (int j = 0; j < 3; j++) begin
      blk[0][j] = rand128();
      blk[1][j] = rand128();
    end
    run_pair(0, 2, 1);
    rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 0;
    check("rr_len", grant_log0.size(), 3);
    for (int j = 0; j < 3 && j < grant_log0.size(); j++)
      check($sformatf("rr_order%0d", j), grant_log0[j], rr_exp[j]);

    // fixed block from req0 alone: 17 writes A0,00,11..FF
    blk[0][0] = 128'h00112233445566778899AABBCCDDEEFF;
    w0 = wr_cnt[0];
    run_pair(0, 1, 0);
    check("fixed_writes", wr_cnt[0] - w0, 17);

    // busy already high when ISSUE is entered: the strobe waits
    blk[0][0] = rand128();
    fbusy[0] = 1'b1;
    model_blocks(0, 1, 0);
    w0 = wr_cnt[0];
    @(posedge clk);
    #1;
    fork
      requester(0, 0, 1);
      begin
        repeat (20) @(negedge clk);
        check("wr_while_busy", wr_cnt[0] - w0, 0);
        check("stall_active", {31'd0, act_w[0]}, 32'd1);
        @(posedge clk);
        #1 fbusy[0] = 1'b0;
      end
    join
    wait_idle(0);
    check("stall_writes", wr_cnt[0] - w0, 17);
    check("stall_done", done_cnt[0], exp_done[0]);

    // random mixes of requesters and data
    for (int it = 0; it < 5; it++) begin
      int n0 = $urandom_range(0, 2);
      int n1 = $urandom_range(0, 2);
      if (n0 + n1 == 0) n0 = 1;
      for (int j = 0; j < 3; j++) begin
        blk[0][j] = rand128();
        blk[1][j] = rand128();
      end
      run_pair(0, n0, n1);
    end
    check("a_err_clean", {31'd0, err_w[0]}, 32'd0);

    // headerless instance: req1 block of all 5A
    blk[1][0] = {16{8'h5A}};
    w0 = wr_cnt[1];
    run_pair(1, 0, 1);
    check("b_writes", wr_cnt[1] - w0, 16);

    // busy never rises after the first write -> timeout, abort, no done
    blk[1][0] = rand128();
    stuck[1] = 1'b1;
    exp_q1.push_back({1'b1, blk[1][0][127:120]});
    ack_q1.push_back(1'b1);
    @(posedge clk);
    #1;
    fork
      requester(1, 1, 1);
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!wr_w[1] && cnt < 100);
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!err_w[1] && cnt < 50);
        check("tmo_cycles", cnt, 6);
      end
    join
    wait_idle(1);
    check("tmo_err", {31'd0, err_w[1]}, 32'd1);
    check("tmo_no_done", done_cnt[1], exp_done[1]);
    stuck[1] = 1'b0;
    blk[0][0] = rand128();
    run_pair(1, 1, 0);
    check("err_sticky", {31'd0, err_w[1]}, 32'd1);

    // reset after the fifth byte of a block
    blk[0][0] = rand128();
    model_blocks(0, 1, 0);
    @(posedge clk);
    #1;
    fork
      requester(0, 0, 1);
      begin
        cnt = 0;
        w0 = 0;
        while (w0 < 5 && cnt < 2000) begin
          @(negedge clk);
          cnt++;
          if (wr_w[0]) w0++;
        end
        if (cnt >= 2000) fail_now("fifth_byte_wait");
      end
    join
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    exp_q0.delete();
    ack_q0.delete();
    exp_done[0]--;
    rr_last[0] = 1;
    rr_last[1] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt[0];
    repeat (30) @(negedge clk);
    check("no_wr_after_rst", wr_cnt[0] - w0, 0);
    check("rst_done", done_cnt[0], exp_done[0]);

    // fresh request restarts at the header
    blk[0][0] = rand128();
    run_pair(0, 1, 0);
    check("final_err_a", {31'd0, err_w[0]}, 32'd0);
    check("final_err_b", {31'd0, err_w[1]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
